// File: rtl/vga_term_writer_if.sv
// Byte-source handshake, text-buffer write port and cursor readback of the terminal writer.
interface vga_term_writer_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned ROW_W  = 7
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_addr, wr_data, wr_en, cur_col, cur_row
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_addr, wr_data, wr_en, cur_col, cur_row
    );
endinterface

// File: rtl/vga_term_writer.sv
// Terminal-style character writer for the VGA text buffer (CR, LF, BS, FF, fill sequences).
// Define VGA_TERM_LINE_CLEAR_EN to clear each newly entered row on wrap or LF.
module vga_term_writer #(
    parameter int unsigned COLS      = 160,
    parameter int unsigned ROWS      = 128,
    parameter int unsigned ADDR_W    = 15,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    vga_term_writer_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

`ifdef VGA_TERM_LINE_CLEAR_EN
    localparam bit LineClear = 1'b1;
`else
    localparam bit LineClear = 1'b0;
`endif

    localparam logic [COL_W-1:0]  ColMax     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  RowMax     = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ColsA      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ColsM1A    = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ScreenLast = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W-1:0] fill_end_q, fill_end_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic              row_last;
    logic [ROW_W-1:0]  row_next;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] next_base;
    logic              advance;
    logic              printable;

    assign row_last  = (row_q == RowMax);
    assign row_next  = row_last ? '0 : row_q + ROW_W'(1);
    assign row_base  = cur_addr_q - ADDR_W'(col_q);
    assign next_base = row_last ? '0 : row_base + ColsA;
    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cur_addr_d  = cur_addr_q;
        fill_addr_d = fill_addr_q;
        fill_end_d  = fill_end_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        advance     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr_q;
                        wr_data_d = bus.in_data;
                        if (col_q == ColMax) begin
                            advance = 1'b1;
                        end else begin
                            col_d      = col_q + COL_W'(1);
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0A: advance = 1'b1;
                            8'h0D: begin
                                col_d      = '0;
                                cur_addr_d = row_base;
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d      = col_q - COL_W'(1);
                                    cur_addr_d = cur_addr_q - ADDR_W'(1);
                                    wr_en_d    = 1'b1;
                                    wr_addr_d  = cur_addr_q - ADDR_W'(1);
                                    wr_data_d  = FILL_CHAR;
                                end
                            end
                            8'h0C: begin
                                col_d       = '0;
                                row_d       = '0;
                                cur_addr_d  = '0;
                                fill_addr_d = '0;
                                fill_end_d  = ScreenLast;
                                state_d     = StFill;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StFill: begin
                wr_en_d   = 1'b1;
                wr_addr_d = fill_addr_q;
                wr_data_d = FILL_CHAR;
                if (fill_addr_q == fill_end_q) begin
                    state_d = StIdle;
                end else begin
                    fill_addr_d = fill_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Row advance shared by column wrap and LF; LF implies CR.
        if (advance) begin
            col_d      = '0;
            row_d      = row_next;
            cur_addr_d = next_base;
            if (LineClear) begin
                state_d     = StFill;
                fill_addr_d = next_base;
                fill_end_d  = next_base + ColsM1A;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            cur_addr_q  <= '0;
            fill_addr_q <= '0;
            fill_end_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cur_addr_q  <= cur_addr_d;
            fill_addr_q <= fill_addr_d;
            fill_end_q  <= fill_end_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.in_ready = (state_q == StIdle);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cur_col  = col_q;
    assign bus.cur_row  = row_q;
endmodule
